// File: rtl/stopwatch_pkg.sv
// Shared constants for the stopwatch display path: active-low segment
// patterns (bit order g..a), the default error word and digit slot indices.
package stopwatch_pkg;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_DASH  = 7'h3F;
   localparam logic [6:0] SEG_E     = 7'h06;
   localparam logic [6:0] SEG_R     = 7'h2F;

   // Entry n is the pattern for digit n; entry 0 sits in the low bits.
   localparam logic [9:0][6:0] SEG_TABLE = {
      7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
      7'h19, 7'h30, 7'h24, 7'h79, 7'h40
   };

   localparam logic [15:0] ERROR_CODE_DEF = 16'h5555;

   localparam logic [1:0] DIG_SEC_U = 2'd0;
   localparam logic [1:0] DIG_SEC_T = 2'd1;
   localparam logic [1:0] DIG_MIN_U = 2'd2;
   localparam logic [1:0] DIG_MIN_T = 2'd3;

endpackage

// File: rtl/bcd_to_7seg.sv
// BCD nibble to active-low 7-segment pattern; purely combinational.
// Non-decimal nibbles (10..15) render as a dash.
module bcd_to_7seg
   import stopwatch_pkg::*;
(
   input  logic [3:0] bcd_dat,
   output logic [6:0] seg_dat
);

   always_comb begin
      seg_dat = SEG_DASH;
      if (bcd_dat <= 4'd9) seg_dat = SEG_TABLE[bcd_dat];
   end

endmodule

// File: rtl/stopwatch_display_driver.sv
// Four-digit multiplexed MM:SS display with frame-aligned value swap and
// blinking colon/error pattern; an/seg/dp/frame_done lag digit_sel by 1 cycle.
module stopwatch_display_driver
   import stopwatch_pkg::*;
#(
   parameter int          REFRESH_DIV  = 50000,
   parameter int          BLINK_FRAMES = 128,
   parameter logic [15:0] ERROR_CODE   = ERROR_CODE_DEF,
   parameter bit          LZ_BLANK     = 1'b1
) (
   input  logic        clk_in,
   input  logic        RESET,
   input  logic [16:1] D_Q,
   input  logic        load,
   output logic [7:1]  seg,
   output logic        dp,
   output logic [4:1]  an,
   output logic        bcd_err,
   output logic        frame_done
);

   localparam int DIV_W = $clog2(REFRESH_DIV);
   localparam int BC_W  = ($clog2(BLINK_FRAMES) > 0) ? $clog2(BLINK_FRAMES) : 1;

   logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
   logic [1:0]       digit_sel_q, digit_sel_d;
   logic [15:0]      shadow_q, shadow_d;
   logic [15:0]      disp_q, disp_d;
   logic             pending_q, pending_d;
   logic [BC_W-1:0]  blink_cnt_q, blink_cnt_d;
   logic             blink_phase_q, blink_phase_d;
   logic [3:0]       an_q, an_d;
   logic [6:0]       seg_q, seg_d;
   logic             dp_q, dp_d;
   logic             frame_done_q, frame_done_d;

   logic       term_cnt, boundary, err_mode;
   logic [3:0] nib;
   logic [6:0] dec_seg;

   bcd_to_7seg u_dec (
      .bcd_dat (nib),
      .seg_dat (dec_seg)
   );

   always_comb begin
      term_cnt = (div_cnt_q == DIV_W'(REFRESH_DIV - 1));
      boundary = term_cnt && (digit_sel_q == DIG_MIN_T);
      err_mode = (disp_q == ERROR_CODE);

      div_cnt_d   = term_cnt ? '0 : div_cnt_q + 1'b1;
      digit_sel_d = term_cnt ? digit_sel_q + 2'd1 : digit_sel_q;

      // Swap uses the shadow as it stood before this cycle's load.
      shadow_d  = shadow_q;
      pending_d = pending_q;
      disp_d    = disp_q;
      if (boundary && pending_q) begin
         disp_d    = shadow_q;
         pending_d = 1'b0;
      end
      if (load) begin
         shadow_d  = D_Q;
         pending_d = 1'b1;
      end

      blink_cnt_d   = blink_cnt_q;
      blink_phase_d = blink_phase_q;
      if (boundary) begin
         if (blink_cnt_q == BC_W'(BLINK_FRAMES - 1)) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
         end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
         end
      end
      frame_done_d = boundary;

      case (digit_sel_q)
         DIG_SEC_U: nib = disp_q[3:0];
         DIG_SEC_T: nib = disp_q[7:4];
         DIG_MIN_U: nib = disp_q[11:8];
         default:   nib = disp_q[15:12];
      endcase

      an_d  = ~(4'b0001 << digit_sel_q);
      seg_d = dec_seg;
      if (err_mode) begin
         seg_d = SEG_BLANK;
         if (!blink_phase_q) begin
            case (digit_sel_q)
               DIG_MIN_T:            seg_d = SEG_E;
               DIG_MIN_U, DIG_SEC_T: seg_d = SEG_R;
               default:              seg_d = SEG_BLANK;
            endcase
         end
      end else if (LZ_BLANK && digit_sel_q == DIG_MIN_T && disp_q[15:12] == 4'd0) begin
         seg_d = SEG_BLANK;
      end
      dp_d = !(!err_mode && digit_sel_q == DIG_MIN_U && !blink_phase_q);

      bcd_err = !err_mode && ((disp_q[3:0] > 4'd9) || (disp_q[7:4] > 4'd9) ||
                              (disp_q[11:8] > 4'd9) || (disp_q[15:12] > 4'd9));
   end

   always_ff @(posedge clk_in) begin
      if (RESET) begin
         div_cnt_q     <= '0;
         digit_sel_q   <= 2'd0;
         shadow_q      <= 16'h0000;
         disp_q        <= 16'h0000;
         pending_q     <= 1'b0;
         blink_cnt_q   <= '0;
         blink_phase_q <= 1'b0;
         an_q          <= 4'hF;
         seg_q         <= SEG_BLANK;
         dp_q          <= 1'b1;
         frame_done_q  <= 1'b0;
      end else begin
         div_cnt_q     <= div_cnt_d;
         digit_sel_q   <= digit_sel_d;
         shadow_q      <= shadow_d;
         disp_q        <= disp_d;
         pending_q     <= pending_d;
         blink_cnt_q   <= blink_cnt_d;
         blink_phase_q <= blink_phase_d;
         an_q          <= an_d;
         seg_q         <= seg_d;
         dp_q          <= dp_d;
         frame_done_q  <= frame_done_d;
      end
   end

   assign an         = an_q;
   assign seg        = seg_q;
   assign dp         = dp_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_stopwatch_display_driver.sv
// Cycle-level scoreboard bench for stopwatch_display_driver (REFRESH_DIV=4,
// BLINK_FRAMES=2): each driven cycle pushes its predicted outputs, popped after the edge.
module tb_stopwatch_display_driver;

   localparam int RD = 4;
   localparam int BF = 2;

   logic        clk_in = 1'b0;
   logic        RESET  = 1'b1;
   logic [16:1] D_Q    = 16'h1234;
   logic        load   = 1'b0;
   logic [7:1]  seg;
   logic        dp;
   logic [4:1]  an;
   logic        bcd_err;
   logic        frame_done;

   stopwatch_display_driver #(
      .REFRESH_DIV  (RD),
      .BLINK_FRAMES (BF),
      .ERROR_CODE   (16'h5555),
      .LZ_BLANK     (1'b1)
   ) dut (
      .clk_in     (clk_in),
      .RESET      (RESET),
      .D_Q        (D_Q),
      .load       (load),
      .seg        (seg),
      .dp         (dp),
      .an         (an),
      .bcd_err    (bcd_err),
      .frame_done (frame_done)
   );

   always #5 clk_in = ~clk_in;

   typedef struct {
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp;
      logic       fd;
      logic       berr;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   int          m_t    = 0;
   logic [15:0] m_disp = 16'h0000;
   logic [15:0] m_sh   = 16'h0000;
   bit          m_pend = 1'b0;

   task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic logic [6:0] ref_seg(input logic [15:0] v, input int d, input bit ph);
      logic [3:0] n;
      n = v[d*4 +: 4];
      if (v == 16'h5555) begin
         if (ph) return 7'h7F;
         if (d == 3) return 7'h06;
         if (d == 0) return 7'h7F;
         return 7'h2F;
      end
      if (d == 3 && v[15:12] == 4'd0) return 7'h7F;
      case (n)
         4'd0: return 7'h40;
         4'd1: return 7'h79;
         4'd2: return 7'h24;
         4'd3: return 7'h30;
         4'd4: return 7'h19;
         4'd5: return 7'h12;
         4'd6: return 7'h02;
         4'd7: return 7'h78;
         4'd8: return 7'h00;
         4'd9: return 7'h10;
         default: return 7'h3F;
      endcase
   endfunction

   function automatic bit ref_berr(input logic [15:0] v);
      if (v == 16'h5555) return 1'b0;
      return (v[3:0] > 9) || (v[7:4] > 9) || (v[11:8] > 9) || (v[15:12] > 9);
   endfunction

   // One clock: predict from current inputs, advance model, compare after the edge.
   task automatic tick();
      exp_t e;
      int   slot;
      bit   bnd, ph;
      if (RESET) begin
         e = '{an: 4'hF, seg: 7'h7F, dp: 1'b1, fd: 1'b0, berr: 1'b0};
         m_t = 0; m_disp = 16'h0; m_sh = 16'h0; m_pend = 1'b0;
      end else begin
         slot  = (m_t / RD) % 4;
         bnd   = (m_t % (4*RD)) == (4*RD - 1);
         ph    = ((m_t / (4*RD)) / BF) % 2;
         e.an  = 4'hF ^ (4'b0001 << slot);
         e.seg = ref_seg(m_disp, slot, ph);
         e.dp  = !(slot == 2 && !ph && m_disp != 16'h5555);
         e.fd  = bnd;
         if (bnd && m_pend) begin
            m_disp = m_sh;
            m_pend = 1'b0;
         end
         if (load) begin
            m_sh   = D_Q;
            m_pend = 1'b1;
         end
         m_t++;
         e.berr = ref_berr(m_disp);
      end
      exp_q.push_back(e);
      @(posedge clk_in);
      #1;
      e = exp_q.pop_front();
      check("an", an, e.an);
      check("seg", seg, e.seg);
      check("dp", dp, e.dp);
      check("frame_done", frame_done, e.fd);
      check("bcd_err", bcd_err, e.berr);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic load_val(input logic [15:0] v);
      D_Q  = v;
      load = 1'b1;
      tick();
      load = 1'b0;
   endtask

   task automatic wait_fd(input string tag);
      for (int i = 0; i < 40 && frame_done !== 1'b1; i++) tick();
      check(tag, frame_done, 1'b1);
   endtask

   task automatic wait_digit(input string tag, input logic [3:0] an_v, input logic [6:0] seg_v);
      for (int i = 0; i < 40 && an !== an_v; i++) tick();
      check({tag, "_an"}, an, an_v);
      check({tag, "_seg"}, seg, seg_v);
   endtask

   initial begin
      // Reset release with unloaded D_Q: display stays 0000.
      RESET = 1'b1;
      run(3);
      check("rst_an", an, 4'hF);
      check("rst_seg", seg, 7'h7F);
      RESET = 1'b0;
      tick();
      check("first_digit_an", an, 4'b1110);
      check("first_digit_seg", seg, 7'h40);
      run(39);

      // Mid-frame load swaps only at the next boundary.
      wait_fd("fd_a");
      run(5);
      load_val(16'h4930);
      wait_digit("old_d1", 4'b1011, 7'h40);
      wait_fd("fd_b");
      wait_digit("new_d1", 4'b1110, 7'h40);
      wait_digit("new_d2", 4'b1101, 7'h30);
      wait_digit("new_d3", 4'b1011, 7'h10);
      wait_digit("new_d4", 4'b0111, 7'h19);

      // Overwrite within one frame: last value wins.
      run(2);
      load_val(16'h1020);
      run(2);
      load_val(16'h1021);
      wait_fd("fd_c");
      wait_digit("ovw_d1", 4'b1110, 7'h79);

      // Load during the boundary cycle is deferred one frame.
      run(3);
      load_val(16'h0555);
      while (m_t % (4*RD) != 4*RD - 1) tick();
      load_val(16'h0666);
      check("coll_fd", frame_done, 1'b1);
      wait_digit("coll_old", 4'b1110, 7'h12);
      wait_fd("fd_d");
      wait_digit("coll_new", 4'b1110, 7'h02);

      // Invalid BCD nibble shows a dash and raises bcd_err after the swap.
      run(3);
      load_val(16'h12A4);
      wait_fd("fd_e");
      check("berr_set", bcd_err, 1'b1);
      wait_digit("dash_d2", 4'b1101, 7'h3F);
      load_val(16'h1234);
      wait_fd("fd_f");
      check("berr_clr", bcd_err, 1'b0);

      // Error word blinks "Err " / blank.
      run(3);
      load_val(16'h5555);
      wait_fd("fd_g");
      check("err_berr", bcd_err, 1'b0);
      run(80);

      // Colon blink, then reset during digit 3 with a pending value.
      load_val(16'h0105);
      run(80);
      wait_digit("pre_rst_d3", 4'b1011, ref_seg(m_disp, 2, ((m_t / (4*RD)) / BF) % 2));
      load_val(16'h0999);
      RESET = 1'b1;
      tick();
      check("midrst_an", an, 4'hF);
      check("midrst_seg", seg, 7'h7F);
      tick();
      RESET = 1'b0;
      wait_digit("post_rst_d1", 4'b1110, 7'h40);
      wait_digit("post_rst_d4", 4'b0111, 7'h7F);
      run(40);
      check("post_rst_berr", bcd_err, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
